bcd_key_entry: RTL and testbench

- Consumes the 4-bit BCD key code and key-valid (CHK) flag from the 10-key decimal encoder stage.
- Debounces each key press and rejects invalid codes.
- Shifts each accepted digit into a DIGITS-wide BCD entry register that feeds the display and compare logic.
- One accepted digit per press; holding the key never repeats.

---
 rtl/bcd_key_entry.sv | 149 ++++++++++++++
 tb/tb_bcd_key_entry.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_key_entry.sv
// Debounced 10-key digit entry: synchronizes chk/bcd_in, accepts one digit per press into a BCD shift register.
// Latency: digit stored DB_CYCLES+3 edges after a stable press; no backpressure, extra digits when full are dropped with err.
module bcd_key_entry #(
  parameter int DIGITS    = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            bcd_in,
  input  logic                  chk,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   digits,
  output logic [3:0]            count,
  output logic                  full,
  output logic                  new_digit,
  output logic                  err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] REL_DB   = 2'd3;

  localparam logic [7:0] CNT_MAX = 8'(DB_CYCLES - 1);
  localparam logic [3:0] DIG_N   = 4'(DIGITS);

  logic                chk_m, chk_s;
  logic [3:0]          bcd_m, bcd_s;
  logic [1:0]          state, state_n;
  logic [3:0]          cand, cand_n;
  logic [7:0]          cnt, cnt_n;
  logic                cnt_done;
  logic                accept;
  logic                store, reject;
  logic [3:0]          count_inc;
  logic [4*DIGITS-1:0] shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_m <= 1'b0;
      chk_s <= 1'b0;
      bcd_m <= 4'd0;
      bcd_s <= 4'd0;
    end else begin
      chk_m <= chk;
      chk_s <= chk_m;
      bcd_m <= bcd_in;
      bcd_s <= bcd_m;
    end
  end

  assign cnt_done = (cnt == CNT_MAX);

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (chk_s) begin
          cand_n  = bcd_s;
          cnt_n   = 8'd0;
          state_n = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!chk_s) begin
          state_n = IDLE;
        end else if (bcd_s != cand) begin
          cand_n = bcd_s;
          cnt_n  = 8'd0;
        end else if (!cnt_done) begin
          cnt_n = cnt + 8'd1;
        end else begin
          accept  = 1'b1;
          state_n = HELD;
        end
      end
      HELD: begin
        // Code changes while held are ignored; only chk release matters.
        if (!chk_s) begin
          cnt_n   = 8'd0;
          state_n = REL_DB;
        end
      end
      REL_DB: begin
        if (chk_s) begin
          state_n = HELD;
        end else if (!cnt_done) begin
          cnt_n = cnt + 8'd1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  generate
    if (DIGITS == 1) begin : g_one
      assign shifted = cand;
    end else begin : g_multi
      assign shifted = {digits[4*DIGITS-5:0], cand};
    end
  endgenerate

  // clr wins over a coinciding accept: the digit is silently dropped.
  assign store     = accept && !clr && (cand <= 4'd9) && !full;
  assign reject    = accept && !clr && ((cand > 4'd9) || full);
  assign count_inc = count + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits    <= '0;
      count     <= 4'd0;
      full      <= 1'b0;
      new_digit <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      digits    <= '0;
      count     <= 4'd0;
      full      <= 1'b0;
      new_digit <= 1'b0;
      err       <= 1'b0;
    end else begin
      new_digit <= store;
      err       <= reject;
      if (store) begin
        digits <= shifted;
        count  <= count_inc;
        full   <= (count_inc == DIG_N);
      end
    end
  end

endmodule

// File: tb/tb_bcd_key_entry.sv
// Directed and randomized key-press bench for bcd_key_entry with a digit-queue reference model.
module tb_bcd_key_entry;
  localparam int DIGITS    = 4;
  localparam int DB_CYCLES = 4;
  localparam int LAT       = DB_CYCLES + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  bcd_in;
  logic        chk;
  logic        clr;
  logic [15:0] digits;
  logic [3:0]  count;
  logic        full;
  logic        new_digit;
  logic        err;

  bcd_key_entry #(.DIGITS(DIGITS), .DB_CYCLES(DB_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .chk(chk), .clr(clr),
    .digits(digits), .count(count), .full(full), .new_digit(new_digit), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int nd_tot = 0;
  int er_tot = 0;
  int both = 0;
  int nd_cyc = -1;
  int start, nd0, er0;
  int v, hold, gap;
  int q[$];

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Samples one cycle, 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (new_digit === 1'b1) begin nd_tot++; nd_cyc = cyc; end
    if (err === 1'b1) er_tot++;
    if (new_digit === 1'b1 && err === 1'b1) both++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int val, input int h, input int g);
    chk = 1'b1;
    bcd_in = 4'(val);
    ticks(h);
    chk = 1'b0;
    bcd_in = 4'd0;
    ticks(g);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    q.delete();
  endtask

  // Model: a press of a valid digit appends to the entry unless already DIGITS long.
  function automatic int model_press(input int val);
    if (val > 9 || q.size() == DIGITS) return 0;
    q.push_back(val);
    return 1;
  endfunction

  function automatic int model_digits();
    int r = 0;
    foreach (q[i]) r = (r * 16) + q[i];
    return r;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_digits"}, int'(digits), model_digits());
    check({tag, "_count"}, int'(count), q.size());
    check({tag, "_full"}, int'(full), int'(q.size() == DIGITS));
  endtask

  initial begin
    int stored;
    rst_n = 1'b0; chk = 1'b0; bcd_in = 4'd0; clr = 1'b0;
    ticks(3);
    check("reset_digits", int'(digits), 0);
    check("reset_count", int'(count), 0);
    check("reset_full", int'(full), 0);
    check("reset_new_digit", int'(new_digit), 0);
    check("reset_err", int'(err), 0);
    rst_n = 1'b1;
    ticks(3);

    // Single press of 7, latency to new_digit.
    nd0 = nd_tot; er0 = er_tot; start = cyc;
    press(7, 20, 10);
    void'(model_press(7));
    check("p7_latency", nd_cyc - start, LAT);
    check("p7_nd_pulses", nd_tot - nd0, 1);
    check("p7_err_pulses", er_tot - er0, 0);
    check_model("p7");

    do_clr();
    check_model("clr1");

    // 1,2,3,4 fills the register.
    nd0 = nd_tot;
    for (int k = 1; k <= 4; k++) begin
      press(k, 10, 10);
      void'(model_press(k));
    end
    check("seq_nd_pulses", nd_tot - nd0, 4);
    check("seq_digits", int'(digits), 'h1234);
    check_model("seq");

    // Press while full.
    nd0 = nd_tot; er0 = er_tot;
    press(5, 10, 10);
    check("full_err_pulses", er_tot - er0, 1);
    check("full_nd_pulses", nd_tot - nd0, 0);
    check("full_digits", int'(digits), 'h1234);
    check("full_count", int'(count), 4);

    // Bounce never accepted.
    do_clr();
    nd0 = nd_tot; er0 = er_tot;
    bcd_in = 4'd3;
    for (int k = 0; k < 5; k++) begin
      chk = 1'b1; ticks(2);
      chk = 1'b0; ticks(1);
      chk = 1'b1; ticks(2);
      chk = 1'b0; ticks(1);
    end
    ticks(10);
    check("bounce_nd_pulses", nd_tot - nd0, 0);
    check("bounce_err_pulses", er_tot - er0, 0);
    check("bounce_digits", int'(digits), 0);
    press(3, 10, 10);
    void'(model_press(3));
    check("bounce_then_press_nd", nd_tot - nd0, 1);
    check_model("bounce_then_press");

    // Invalid code.
    nd0 = nd_tot; er0 = er_tot;
    press('hA, 10, 10);
    void'(model_press('hA));
    check("inv_err_pulses", er_tot - er0, 1);
    check("inv_nd_pulses", nd_tot - nd0, 0);
    check_model("inv");

    // clr coinciding with the accept edge; held key not re-accepted.
    nd0 = nd_tot; er0 = er_tot;
    chk = 1'b1; bcd_in = 4'd6;
    ticks(LAT - 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    q.delete();
    ticks(13);
    chk = 1'b0;
    ticks(10);
    check("clr_acc_nd_pulses", nd_tot - nd0, 0);
    check("clr_acc_err_pulses", er_tot - er0, 0);
    check_model("clr_acc");

    // Reset in the middle of a press of 9.
    press(2, 10, 10);
    void'(model_press(2));
    chk = 1'b1; bcd_in = 4'd9;
    ticks(5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_digits", int'(digits), 0);
    check("rst_mid_count", int'(count), 0);
    ticks(3);
    check("rst_hold_nd", int'(new_digit), 0);
    check("rst_hold_full", int'(full), 0);
    q.delete();
    rst_n = 1'b1;
    nd0 = nd_tot; start = cyc;
    ticks(15);
    chk = 1'b0;
    ticks(10);
    void'(model_press(9));
    check("rst_rel_latency", nd_cyc - start, LAT);
    check("rst_rel_nd_pulses", nd_tot - nd0, 1);
    check_model("rst_rel");

    // Randomized clean presses with occasional clears.
    do_clr();
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_clr();
        ticks(2);
      end
      v = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 9) : $urandom_range(10, 15);
      hold = $urandom_range(8, 16);
      gap = $urandom_range(8, 14);
      nd0 = nd_tot; er0 = er_tot;
      press(v, hold, gap);
      stored = model_press(v);
      check("rnd_nd_pulses", nd_tot - nd0, stored);
      check("rnd_err_pulses", er_tot - er0, 1 - stored);
      check_model("rnd");
    end

    check("pulse_overlap", both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
